// File: rtl/hms_pkg.sv
// Shared constants and types for the hour/minute/second time core.
package hms_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned RING_W  = 6;

endpackage

// File: rtl/hms_time_core_wrap_cnt.sv
// Modulo-(MAX+1) up-counter with a combinational carry out for chaining.
module wrap_cnt #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_carry
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_max;

  assign at_max  = (cnt_q == W'(MAX));
  assign o_carry = i_inc & at_max;
  assign o_cnt   = cnt_q;

  // Next count: step on i_inc, wrapping at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hms_time_core.sv
// Time-of-day core: prescaler, h/m/s chain, mode/cursor control and one-alarm compare.
module hms_time_core
  import hms_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned HOURS     = 24,
  parameter int unsigned ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode_pulse,
  input  logic       i_pos_pulse,
  input  logic       i_inc_pulse,
  input  logic       i_alarm_en,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [5:0] o_alarm_min,
  output logic [4:0] o_alarm_hour,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_tick,
  output logic       o_alarm
);

  localparam int unsigned PreW = $clog2(TICK_DIV);

  logic [PreW-1:0]   presc_q, presc_d;
  mode_e             mode_q, mode_d;
  pos_e              pos_q, pos_d;
  logic [MIN_W-1:0]  amin_q, amin_d;
  logic [HOUR_W-1:0] ahour_q, ahour_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic              alarm_q, alarm_d;
  logic              tick_q;

  logic in_setup, in_alarm, enter_setup;
  logic tick, edit_sec, edit_min, edit_hour;
  logic sec_inc, min_inc, hour_inc, sec_carry, min_carry, hour_carry;
  logic [MIN_W-1:0]  min_nx;
  logic [HOUR_W-1:0] hour_nx;
  logic match, clr;

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_CLOCK;
    else        mode_q <= mode_d;
  end

  // Mode FSM next state: simple ring CLOCK -> SETUP -> ALARM -> CLOCK.
  always_comb begin
    mode_d = mode_q;
    if (i_mode_pulse) begin
      unique case (mode_q)
        MODE_CLOCK: mode_d = MODE_SETUP;
        MODE_SETUP: mode_d = MODE_ALARM;
        MODE_ALARM: mode_d = MODE_CLOCK;
        default:    mode_d = MODE_CLOCK;
      endcase
    end
  end

  // Mode FSM outputs: decoded mode flags.
  always_comb begin
    o_mode      = mode_q;
    in_setup    = (mode_q == MODE_SETUP);
    in_alarm    = (mode_q == MODE_ALARM);
    enter_setup = !in_setup && (mode_d == MODE_SETUP);
  end

  // Cursor next state; independent of mode.
  always_comb begin
    pos_d = pos_q;
    if (i_pos_pulse) begin
      unique case (pos_q)
        POS_SEC:  pos_d = POS_MIN;
        POS_MIN:  pos_d = POS_HOUR;
        POS_HOUR: pos_d = POS_SEC;
        default:  pos_d = POS_SEC;
      endcase
    end
  end

  // Prescaler next state: held at 0 in SETUP so leaving SETUP restarts a full second.
  always_comb begin
    tick    = !in_setup && (presc_q == PreW'(TICK_DIV - 1));
    presc_d = presc_q + PreW'(1);
    if (in_setup || tick) presc_d = '0;
  end

  assign edit_sec  = in_setup && i_inc_pulse && (pos_q == POS_SEC);
  assign edit_min  = in_setup && i_inc_pulse && (pos_q == POS_MIN);
  assign edit_hour = in_setup && i_inc_pulse && (pos_q == POS_HOUR);

  // Carries only propagate on a tick; a SETUP edit never ripples into the next field.
  assign sec_inc  = tick | edit_sec;
  assign min_inc  = (tick & sec_carry) | edit_min;
  assign hour_inc = (tick & min_carry) | edit_hour;

  wrap_cnt #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (sec_inc),
    .o_cnt  (o_sec),
    .o_carry(sec_carry)
  );

  wrap_cnt #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (min_inc),
    .o_cnt  (o_min),
    .o_carry(min_carry)
  );

  wrap_cnt #(.MAX(HOURS - 1), .W(HOUR_W)) u_hour (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (hour_inc),
    .o_cnt  (o_hour),
    .o_carry(hour_carry)
  );

  // Alarm time edits; cursor at SEC has no alarm field.
  always_comb begin
    amin_d  = amin_q;
    ahour_d = ahour_q;
    if (in_alarm && i_inc_pulse) begin
      if (pos_q == POS_MIN) begin
        amin_d = (amin_q == MIN_W'(MIN_MAX)) ? '0 : amin_q + MIN_W'(1);
      end else if (pos_q == POS_HOUR) begin
        ahour_d = (ahour_q == HOUR_W'(HOURS - 1)) ? '0 : ahour_q + HOUR_W'(1);
      end
    end
  end

  // Match compares the post-tick time; only meaningful when seconds roll over to 0.
  always_comb begin
    min_nx  = min_carry ? '0 : o_min + MIN_W'(1);
    hour_nx = hour_carry ? '0 : (min_carry ? o_hour + HOUR_W'(1) : o_hour);
    match   = tick && sec_carry && i_alarm_en && (min_nx == amin_q) && (hour_nx == ahour_q);
    clr     = i_inc_pulse || !i_alarm_en || enter_setup;
  end

  // Ring control: clear wins over a fresh match, then countdown on ticks.
  always_comb begin
    alarm_d = alarm_q;
    ring_d  = ring_q;
    if (clr) begin
      alarm_d = 1'b0;
      ring_d  = '0;
    end else if (match) begin
      alarm_d = 1'b1;
      ring_d  = RING_W'(ALARM_SEC);
    end else if (alarm_q && tick) begin
      ring_d = ring_q - RING_W'(1);
      if (ring_q == RING_W'(1)) alarm_d = 1'b0;
    end
  end

  // Control and alarm state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pos_q   <= POS_SEC;
      amin_q  <= '0;
      ahour_q <= '0;
      ring_q  <= '0;
      alarm_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
      amin_q  <= amin_d;
      ahour_q <= ahour_d;
      ring_q  <= ring_d;
      alarm_q <= alarm_d;
      tick_q  <= tick;
    end
  end

  assign o_alarm_min  = amin_q;
  assign o_alarm_hour = ahour_q;
  assign o_position   = pos_q;
  assign o_sec_tick   = tick_q;
  assign o_alarm      = alarm_q;

endmodule

// File: tb/tb_hms_time_core.sv
// Self-checking bench for hms_time_core with TICK_DIV=4, ALARM_SEC=3 (24h and 12h instances).
module tb_hms_time_core;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_mode_pulse = 1'b0;
  logic i_pos_pulse = 1'b0;
  logic i_inc_pulse = 1'b0;
  logic i_alarm_en = 1'b0;

  logic [5:0] o_sec, o_min, o_alarm_min, s12, m12, am12;
  logic [4:0] o_hour, o_alarm_hour, h12, ah12;
  logic [1:0] o_mode, o_position, md12, ps12;
  logic       o_sec_tick, o_alarm, tk12, al12;

  always #5 clk = ~clk;

  hms_time_core #(.TICK_DIV(4), .HOURS(24), .ALARM_SEC(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mode_pulse(i_mode_pulse),
    .i_pos_pulse (i_pos_pulse),
    .i_inc_pulse (i_inc_pulse),
    .i_alarm_en  (i_alarm_en),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
    .o_alarm_min (o_alarm_min),
    .o_alarm_hour(o_alarm_hour),
    .o_mode      (o_mode),
    .o_position  (o_position),
    .o_sec_tick  (o_sec_tick),
    .o_alarm     (o_alarm)
  );

  hms_time_core #(.TICK_DIV(4), .HOURS(12), .ALARM_SEC(3)) dut12 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mode_pulse(i_mode_pulse),
    .i_pos_pulse (i_pos_pulse),
    .i_inc_pulse (i_inc_pulse),
    .i_alarm_en  (i_alarm_en),
    .o_sec       (s12),
    .o_min       (m12),
    .o_hour      (h12),
    .o_alarm_min (am12),
    .o_alarm_hour(ah12),
    .o_mode      (md12),
    .o_position  (ps12),
    .o_sec_tick  (tk12),
    .o_alarm     (al12)
  );

  wire [33:0] obs = {o_sec, o_min, o_hour, o_alarm_min, o_alarm_hour, o_mode, o_position,
                     o_sec_tick, o_alarm};
  wire [33:0] obs12 = {s12, m12, h12, am12, ah12, md12, ps12, tk12, al12};

  typedef struct {
    string       name;
    logic [33:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [33:0] mk(input int s, input int m, input int h, input int am,
                                     input int ah, input int md, input int ps, input int tk,
                                     input int al);
    return {6'(s), 6'(m), 5'(h), 6'(am), 5'(ah), 2'(md), 2'(ps), 1'(tk), 1'(al)};
  endfunction

  function automatic exp_t ex(input string n, input logic [33:0] v);
    exp_t e;
    e.name = n;
    e.v    = v;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic p, input logic i);
    i_mode_pulse = m;
    i_pos_pulse  = p;
    i_inc_pulse  = i;
    @(posedge clk);
    #1;
    i_mode_pulse = 1'b0;
    i_pos_pulse  = 1'b0;
    i_inc_pulse  = 1'b0;
  endtask

  task automatic hold_inc(input int n);
    i_inc_pulse = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    i_inc_pulse = 1'b0;
  endtask

  task automatic do_reset();
    i_mode_pulse = 1'b0;
    i_pos_pulse  = 1'b0;
    i_inc_pulse  = 1'b0;
    i_alarm_en   = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(ex("reset_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst_n = 1'b1;
    sb.push_back(ex("pre_first_tick", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(3);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back(ex("first_tick", mk(1, 0, 0, 0, 0, 0, 0, 1, 0)));
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back(ex("tick_one_cycle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back(ex("one_minute", mk(0, 1, 0, 0, 0, 0, 0, 1, 0)));
    step(235);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_preload_rollover();
    exp_t e;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    hold_inc(59);
    pulse(1'b0, 1'b1, 1'b0);
    hold_inc(59);
    pulse(1'b0, 1'b1, 1'b0);
    hold_inc(23);
    e = ex("preload_24h", mk(59, 59, 23, 0, 0, 1, 2, 0, 0)); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    e = ex("preload_12h", mk(59, 59, 11, 0, 0, 1, 2, 0, 0)); n_checks++;
    if (obs12 !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs12, e.v); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("hold_before_tick", mk(59, 59, 23, 0, 0, 0, 2, 0, 0)));
    step(2);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back(ex("rollover_24h", mk(0, 0, 0, 0, 0, 0, 2, 1, 0)));
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    e = ex("rollover_12h", mk(0, 0, 0, 0, 0, 0, 2, 1, 0)); n_checks++;
    if (obs12 !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs12, e.v); end
  endtask

  task automatic test_setup_wrap();
    exp_t e;
    int   n_ticks;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("setup_min59", mk(0, 59, 0, 0, 0, 1, 1, 0, 0)));
    hold_inc(59);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back(ex("setup_min_wrap_no_carry", mk(0, 0, 0, 0, 0, 1, 1, 0, 0)));
    pulse(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    n_ticks = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (o_sec_tick) n_ticks++;
    end
    n_checks++;
    if (n_ticks != 0) begin
      n_errors++; $display("FAIL setup_no_ticks: got %0d ticks expected 0", n_ticks);
    end
    e = ex("setup_frozen", mk(0, 0, 0, 0, 0, 1, 1, 0, 0)); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    pulse(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("leave_setup_wait", mk(0, 0, 0, 0, 0, 2, 1, 0, 0)));
    step(3);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back(ex("leave_setup_first_tick", mk(1, 0, 0, 0, 0, 2, 1, 1, 0)));
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_alarm_ring();
    exp_t e;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("alarm_inc_at_sec", mk(0, 0, 0, 0, 0, 2, 0, 0, 0)));
    pulse(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    i_alarm_en = 1'b1;
    sb.push_back(ex("ring_0100", mk(0, 1, 0, 1, 0, 0, 1, 1, 1)));
    sb.push_back(ex("ring_0101", mk(1, 1, 0, 1, 0, 0, 1, 1, 1)));
    sb.push_back(ex("ring_0102", mk(2, 1, 0, 1, 0, 0, 1, 1, 1)));
    sb.push_back(ex("ring_0103_off", mk(3, 1, 0, 1, 0, 0, 1, 1, 0)));
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      step(1);
      if (o_sec_tick && o_min == 6'd1) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.v) begin
          n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL ring_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    i_alarm_en = 1'b0;
  endtask

  task automatic test_alarm_clear();
    exp_t e;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    i_alarm_en = 1'b1;
    for (int c = 0; c < 400 && !o_alarm; c++) step(1);
    n_checks++;
    if (o_alarm !== 1'b1) begin
      n_errors++; $display("FAIL clear_wait_rise: got %b expected 1", o_alarm);
    end
    sb.push_back(ex("clear_by_inc", mk(0, 1, 0, 1, 0, 0, 1, 0, 0)));
    pulse(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    i_alarm_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("mode_and_inc", mk(0, 0, 1, 0, 0, 2, 2, 0, 0)));
    pulse(1'b1, 1'b0, 1'b1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    step(2);
    sb.push_back(ex("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b0;
    #1;
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    step(1);
    rst_n = 1'b1;
    sb.push_back(ex("no_tick_on_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step(1);
    e = sb.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    test_reset();
    test_preload_rollover();
    test_setup_wrap();
    test_alarm_ring();
    test_alarm_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hms_time_core.md
# hms_time_core

Synchronous time-of-day core for the segment clock: a parametrised hour/minute/second counter with a setup mode, a position cursor and a one-alarm compare. All state runs on the single system clock and advances on an internal one-second enable, not on derived clocks. Inputs are single-cycle, already-debounced button pulses. Outputs feed the two-digit splitters and the display multiplexer directly.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per second; ≥ 2.
- HOURS, 24: hour modulus, so the hour counts 0..HOURS-1; 2..32.
- ALARM_SEC, 30: number of seconds o_alarm stays high after a match; 1..63.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_mode_pulse  in  1  one-cycle pulse; advances the mode.
- i_pos_pulse  in  1  one-cycle pulse; advances the position cursor.
- i_inc_pulse  in  1  one-cycle pulse; increments the selected field, or acknowledges the alarm.
- i_alarm_en  in  1  level; arms the alarm compare.
- o_sec  out  6  seconds, 0..59.
- o_min  out  6  minutes, 0..59.
- o_hour  out  5  hours, 0..HOURS-1.
- o_alarm_min  out  6  alarm minute.
- o_alarm_hour  out  5  alarm hour.
- o_mode  out  2  current mode: CLOCK=0, SETUP=1, ALARM=2.
- o_position  out  2  cursor: SEC=0, MIN=1, HOUR=2.
- o_sec_tick  out  1  one-cycle pulse on every one-second boundary.
- o_alarm  out  1  alarm ringing.

## Operation
- Reset values: every output is 0; the prescaler is 0; the ring counter is 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while o_mode≠SETUP. The tick fires when the count equals TICK_DIV-1, and the count then wraps to 0.
  - Held at 0 while in SETUP.
- Time advance, on a tick:
  - o_sec increments; 59 wraps to 0 with a carry to o_min.
  - o_min 59 wraps to 0 with a carry to o_hour.
  - o_hour HOURS-1 wraps to 0.
  - The whole carry chain resolves on the same edge.
- Mode FSM: CLOCK→SETUP→ALARM→CLOCK on each i_mode_pulse. No other transitions.
- Position cursor: SEC→MIN→HOUR→SEC on each i_pos_pulse, in any mode. The cursor is not reset when the mode changes.
- i_inc_pulse in SETUP: increments the time field under the cursor modulo that field's range. No carry into the next field.
- i_inc_pulse in ALARM:
  - Increments o_alarm_min or o_alarm_hour modulo its range.
  - Ignored when the cursor is at SEC.
  - Time keeps running in this mode.
- i_inc_pulse in CLOCK: no field change.
- Alarm match:
  - Condition: a tick that moves the time to o_alarm_hour:o_alarm_min:00, with i_alarm_en=1 and the mode not SETUP.
  - Effect: o_alarm rises on that edge and the ring counter loads ALARM_SEC.
  - Each later tick decrements the ring counter; o_alarm falls on the tick that reaches 0.
- Alarm clear: o_alarm clears on the next edge if any of the following occurs: i_inc_pulse in any mode, i_alarm_en=0, or entry into SETUP. In the ALARM mode case, the i_inc_pulse still applies its field edit.
- Simultaneous pulses on one edge: i_inc_pulse is evaluated against the pre-edge mode and cursor; the mode and cursor then update on that same edge.
- Tick together with a SETUP edit cannot occur, because the prescaler is held in SETUP.
- Tick together with an ALARM-mode edit: both are applied, to different registers.
- Leaving SETUP: the prescaler restarts from 0, so the first tick comes TICK_DIV cycles after the mode edge.
- Entering SETUP: a partial prescaler count is discarded.
- Reset asserted mid-operation: all state returns to the reset values asynchronously. No tick is emitted when reset is released.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- First o_sec_tick is in the cycle that ends TICK_DIV edges after rst_n rises. o_sec=1 is visible in the same cycle as o_sec_tick, and o_sec_tick is high for exactly one cycle.
- Pulse-to-output latency is 1 edge for i_inc_pulse, i_mode_pulse and i_pos_pulse.
- A pulse input held high for N cycles counts as N pulses. The upstream debouncer guarantees a single cycle.

## Structure
- Package hms_pkg holds:
  - the mode constants MODE_CLOCK/SETUP/ALARM (2-bit);
  - the cursor constants POS_SEC/MIN/HOUR (2-bit);
  - SEC_MAX=59, MIN_MAX=59;
  - the field widths 6/6/5.
- Sub-module wrap_cnt, parametrised by MAX and W, instantiated three times for sec/min/hour:
  - inputs: clk, rst_n, i_inc;
  - outputs: o_cnt, o_carry (combinational, i_inc & at MAX).
- The prescaler, mode FSM, alarm registers and ring counter stay in the top level.

## Test plan
- Run all scenarios with TICK_DIV=4 unless stated.
- Reset release, run 4 cycles → o_sec_tick pulses once and o_sec=1; after 240 cycles o_min=1, o_sec=0.
- Preload 23:59:59 via SETUP edits, return to CLOCK, one tick → 00:00:00 in one edge. With HOURS=12, 11:59:59 → 00:00:00.
- SETUP, cursor MIN, o_min=59, i_inc_pulse → o_min=0 and o_hour unchanged. Prescaler stays 0 for 100 cycles, and o_sec is frozen.
- ALARM mode with cursor SEC, i_inc_pulse → alarm registers unchanged. Then set the alarm to 00:01 with i_alarm_en=1 and ALARM_SEC=3 → o_alarm rises at 00:01:00 and falls at 00:01:03.
- Ringing alarm, i_inc_pulse in CLOCK → o_alarm=0 next edge, time unaffected.
- i_mode_pulse and i_inc_pulse on the same edge while in SETUP with cursor HOUR → o_hour increments and o_mode=ALARM. Then rst_n low mid-count → all outputs 0 immediately.
